// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one word read per fetch request and feeds the IR.
// Optional next-line prefetch buffer enabled with `define FETCH_PREFETCH_EN.
module instr_fetch_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              flush,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic [DATA_W-1:0] instr_out,
   output logic [1:0]        ir_control,
   output logic              fetch_done,
   output logic              busy,
   output logic              misalign_err,
   output logic              timeout_err
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             drop_pending;
   logic             hshk;
   logic             rsp_live;

   assign hshk       = mem_req_valid && mem_req_ready;
   // a response arriving while a drop is owed belongs to an abandoned request
   assign rsp_live   = mem_rsp_valid && !drop_pending;
   assign ir_control = rst_n ? {1'b0, fetch_done} : 2'b10;

`ifdef FETCH_PREFETCH_EN
   typedef enum logic [1:0] {PF_NONE, PF_REQ, PF_WAIT} pf_state_t;

   pf_state_t         pf_state;
   logic              pbuf_valid;
   logic [DATA_W-1:0] pbuf_data;
   logic              pf_hit;
   logic              pf_kill;

   // mem_req_addr doubles as the buffer tag while a prefetch is held or in flight
   assign pf_hit  = (fetch_pc == mem_req_addr) && (pbuf_valid || pf_state != PF_NONE);
   assign pf_kill = (pf_state == PF_WAIT && !rsp_live) || (pf_state == PF_REQ && hshk);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         drop_pending  <= 1'b0;
         instr_out     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         fetch_done    <= 1'b0;
         busy          <= 1'b0;
         misalign_err  <= 1'b0;
         timeout_err   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
         pf_state      <= PF_NONE;
         pbuf_valid    <= 1'b0;
         pbuf_data     <= '0;
`endif
      end else begin
         fetch_done   <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         if (drop_pending && mem_rsp_valid)
            drop_pending <= 1'b0;
         if (flush) begin
            if ((state == WAIT && !rsp_live) || (state == REQ && hshk))
               drop_pending <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            if (state == IDLE && pf_kill)
               drop_pending <= 1'b1;
            pf_state   <= PF_NONE;
            pbuf_valid <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
`ifdef FETCH_PREFETCH_EN
                  if (pf_state == PF_REQ && hshk) begin
                     pf_state      <= PF_WAIT;
                     mem_req_valid <= 1'b0;
                  end
                  if (pf_state == PF_WAIT && rsp_live) begin
                     pf_state   <= PF_NONE;
                     pbuf_valid <= 1'b1;
                     pbuf_data  <= mem_rsp_data;
                  end
`endif
                  if (fetch_req) begin
                     if (fetch_pc[1:0] != 2'b00)
                        misalign_err <= 1'b1;
`ifdef FETCH_PREFETCH_EN
                     else if (pf_hit) begin
                        // adopt the prefetch as this fetch
                        pf_state   <= PF_NONE;
                        pbuf_valid <= 1'b0;
                        busy       <= 1'b1;
                        wait_cnt   <= '0;
                        if (pbuf_valid || (pf_state == PF_WAIT && rsp_live)) begin
                           instr_out  <= pbuf_valid ? pbuf_data : mem_rsp_data;
                           fetch_done <= 1'b1;
                           state      <= DONE;
                        end else if (pf_state == PF_WAIT || hshk)
                           state <= WAIT;
                        else
                           state <= REQ;
                     end
`endif
                     else begin
`ifdef FETCH_PREFETCH_EN
                        if (pf_kill)
                           drop_pending <= 1'b1;
                        pf_state   <= PF_NONE;
                        pbuf_valid <= 1'b0;
`endif
                        mem_req_addr  <= fetch_pc;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= REQ;
                     end
                  end
               end
               REQ: begin
                  if (hshk) begin
                     mem_req_valid <= 1'b0;
                     wait_cnt      <= '0;
                     state         <= WAIT;
                  end
               end
               WAIT: begin
                  if (rsp_live) begin
                     instr_out  <= mem_rsp_data;
                     fetch_done <= 1'b1;
                     state      <= DONE;
                  end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     timeout_err <= 1'b1;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end else
                     wait_cnt <= wait_cnt + CNT_W'(1);
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
`ifdef FETCH_PREFETCH_EN
                  mem_req_addr  <= mem_req_addr + ADDR_W'(4);
                  mem_req_valid <= 1'b1;
                  pf_state      <= PF_REQ;
                  pbuf_valid    <= 1'b0;
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: vector table, directed reset/timeout sequences and
// randomized fetch transactions predicted at transaction level.
module tb_instr_fetch_ctrl;
   localparam int   TO = 4;
   localparam logic H  = 1'b1;
   localparam logic L  = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, flush, mem_req_ready, mem_rsp_valid;
   logic [31:0] fetch_pc, mem_rsp_data;
   logic        mem_req_valid, fetch_done, busy, misalign_err, timeout_err;
   logic [31:0] mem_req_addr, instr_out;
   logic [1:0]  ir_control;

   int checks = 0;
   int errors = 0;

   instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .instr_out(instr_out), .ir_control(ir_control),
      .fetch_done(fetch_done), .busy(busy), .misalign_err(misalign_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic req; logic [31:0] pc; logic fl; logic rdy; logic rv; logic [31:0] dat;
      logic e_rv; logic [31:0] e_addr; logic e_done; logic e_busy; logic e_mis;
      logic [31:0] e_instr;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic req, input logic [31:0] pc, input logic fl,
                      input logic rdy, input logic rv, input logic [31:0] dat,
                      input logic e_rv, input logic [31:0] e_addr, input logic e_done,
                      input logic e_busy, input logic e_mis, input logic [31:0] e_instr);
      vec_t v;
      v = '{req, pc, fl, rdy, rv, dat, e_rv, e_addr, e_done, e_busy, e_mis, e_instr};
      tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_addr,
                          input logic e_done, input logic e_busy, input logic e_mis,
                          input logic e_to, input logic [31:0] e_instr);
      chk($sformatf("%s req_valid", tag), 32'(mem_req_valid), 32'(e_rv));
      chk($sformatf("%s req_addr", tag), mem_req_addr, e_addr);
      chk($sformatf("%s fetch_done", tag), 32'(fetch_done), 32'(e_done));
      chk($sformatf("%s busy", tag), 32'(busy), 32'(e_busy));
      chk($sformatf("%s misalign", tag), 32'(misalign_err), 32'(e_mis));
      chk($sformatf("%s timeout", tag), 32'(timeout_err), 32'(e_to));
      chk($sformatf("%s instr", tag), instr_out, e_instr);
      chk($sformatf("%s ir_control", tag), 32'(ir_control), {30'b0, 1'b0, e_done});
   endtask

   task automatic idle_inputs();
      fetch_req = L; fetch_pc = '0; flush = L; mem_req_ready = L;
      mem_rsp_valid = L; mem_rsp_data = '0;
   endtask

   task automatic reset_outputs_zero(input string tag);
      chk($sformatf("%s req_valid", tag), 32'(mem_req_valid), 32'd0);
      chk($sformatf("%s req_addr", tag), mem_req_addr, 32'd0);
      chk($sformatf("%s instr", tag), instr_out, 32'd0);
      chk($sformatf("%s flags", tag),
          32'({fetch_done, busy, misalign_err, timeout_err}), 32'd0);
      chk($sformatf("%s ir_control", tag), 32'(ir_control), 32'd2);
   endtask

   logic [31:0] exp_instr, exp_addr;

   // One randomized fetch; expected outputs follow from the transaction
   // parameters alone: ready delay, response latency in WAIT cycles, alignment.
   task automatic rand_txn(input int n);
      logic [31:0] pc, dat;
      int          rdly, lat;
      string       t;
      t    = $sformatf("rnd%0d", n);
      pc   = $urandom;
      pc[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdly = $urandom_range(0, 3);
      lat  = $urandom_range(0, TO);
      dat  = $urandom;
      fetch_req = H; fetch_pc = pc;
      step();
      fetch_req = L;
      if (pc[1:0] != 2'b00) begin
         chk_all({t, " mis"}, L, exp_addr, L, L, H, L, exp_instr);
         step();
         chk_all({t, " mis+1"}, L, exp_addr, L, L, L, L, exp_instr);
         return;
      end
      exp_addr = pc;
      chk_all({t, " req"}, H, exp_addr, L, H, L, L, exp_instr);
      for (int i = 0; i < rdly; i++) begin
         step();
         chk_all({t, " stall"}, H, exp_addr, L, H, L, L, exp_instr);
      end
      mem_req_ready = H;
      step();
      mem_req_ready = L;
      chk_all({t, " wait"}, L, exp_addr, L, H, L, L, exp_instr);
      for (int k = 1; k <= TO; k++) begin
         if (k == lat + 1) begin
            mem_rsp_valid = H; mem_rsp_data = dat;
            step();
            mem_rsp_valid = L;
            exp_instr = dat;
            chk_all({t, " done"}, L, exp_addr, H, H, L, L, exp_instr);
            step();
            chk_all({t, " idle"}, L, exp_addr, L, L, L, L, exp_instr);
            return;
         end
         step();
         if (k < TO) chk_all({t, " waitk"}, L, exp_addr, L, H, L, L, exp_instr);
         else        chk_all({t, " tmo"}, L, exp_addr, L, L, L, H, exp_instr);
      end
      // a late response after abandonment is ignored
      mem_rsp_valid = H; mem_rsp_data = ~dat;
      step();
      mem_rsp_valid = L;
      chk_all({t, " late"}, L, exp_addr, L, L, L, L, exp_instr);
   endtask

   initial begin
      idle_inputs();
      rst_n = L;
      repeat (2) @(posedge clk);
      #1;
      reset_outputs_zero("reset");
      rst_n = H;
      step();
      exp_instr = '0;
      exp_addr  = '0;

`ifdef FETCH_PREFETCH_EN
      fetch_req = H; fetch_pc = 32'h1000; step(); fetch_req = L;
      chk_all("pf req", H, 32'h1000, L, H, L, L, 32'h0);
      mem_req_ready = H; step(); mem_req_ready = L;
      chk_all("pf wait", L, 32'h1000, L, H, L, L, 32'h0);
      mem_rsp_valid = H; mem_rsp_data = 32'h0050_0093; step(); mem_rsp_valid = L;
      chk_all("pf done", L, 32'h1000, H, H, L, L, 32'h0050_0093);
      step();
      chk_all("pf issue", H, 32'h1004, L, L, L, L, 32'h0050_0093);
      mem_req_ready = H; step(); mem_req_ready = L;
      chk_all("pf inflight", L, 32'h1004, L, L, L, L, 32'h0050_0093);
      mem_rsp_valid = H; mem_rsp_data = 32'h00A0_0113; step(); mem_rsp_valid = L;
      chk_all("pf filled", L, 32'h1004, L, L, L, L, 32'h0050_0093);
      fetch_req = H; fetch_pc = 32'h1004; step(); fetch_req = L;
      chk_all("pf hit", L, 32'h1004, H, H, L, L, 32'h00A0_0113);
      step();
      chk_all("pf next", H, 32'h1008, L, L, L, L, 32'h00A0_0113);
      fetch_req = H; fetch_pc = 32'h3000; step(); fetch_req = L;
      chk_all("pf miss", H, 32'h3000, L, H, L, L, 32'h00A0_0113);
      mem_req_ready = H; step(); mem_req_ready = L;
      chk_all("pf miss wait", L, 32'h3000, L, H, L, L, 32'h00A0_0113);
      mem_rsp_valid = H; mem_rsp_data = 32'h0000_0513; step(); mem_rsp_valid = L;
      chk_all("pf miss done", L, 32'h3000, H, H, L, L, 32'h0000_0513);
`else
      //  req pc           fl rdy rv dat            | rv addr         done busy mis instr
      add(H, 32'h1000,     L, L, L, 32'h0,          H, 32'h1000, L, H, L, 32'h0);
      add(L, 32'h0,        L, H, L, 32'h0,          L, 32'h1000, L, H, L, 32'h0);
      add(L, 32'h0,        L, L, H, 32'h0050_0093,  L, 32'h1000, H, H, L, 32'h0050_0093);
      add(L, 32'h0,        L, L, L, 32'h0,          L, 32'h1000, L, L, L, 32'h0050_0093);
      add(H, 32'h1002,     L, L, L, 32'h0,          L, 32'h1000, L, L, H, 32'h0050_0093);
      add(L, 32'h0,        L, L, L, 32'h0,          L, 32'h1000, L, L, L, 32'h0050_0093);
      add(H, 32'h2000,     L, L, H, 32'h1111,       H, 32'h2000, L, H, L, 32'h0050_0093);
      add(L, 32'h0,        L, H, L, 32'h0,          L, 32'h2000, L, H, L, 32'h0050_0093);
      add(L, 32'h0,        H, L, L, 32'h0,          L, 32'h2000, L, L, L, 32'h0050_0093);
      add(H, 32'h2000,     L, L, L, 32'h0,          H, 32'h2000, L, H, L, 32'h0050_0093);
      add(L, 32'h0,        L, H, L, 32'h0,          L, 32'h2000, L, H, L, 32'h0050_0093);
      add(L, 32'h0,        L, L, H, 32'hDEAD_BEEF,  L, 32'h2000, L, H, L, 32'h0050_0093);
      add(L, 32'h0,        L, L, H, 32'h00A0_0113,  L, 32'h2000, H, H, L, 32'h00A0_0113);
      add(L, 32'h0,        L, L, L, 32'h0,          L, 32'h2000, L, L, L, 32'h00A0_0113);
      add(H, 32'h4000,     H, L, L, 32'h0,          L, 32'h2000, L, L, L, 32'h00A0_0113);
      add(L, 32'h0,        L, L, L, 32'h0,          L, 32'h2000, L, L, L, 32'h00A0_0113);
      add(H, 32'h6000,     L, L, L, 32'h0,          H, 32'h6000, L, H, L, 32'h00A0_0113);
      add(L, 32'h0,        H, L, L, 32'h0,          L, 32'h6000, L, L, L, 32'h00A0_0113);
      add(L, 32'h0,        L, L, H, 32'h7777,       L, 32'h6000, L, L, L, 32'h00A0_0113);
      foreach (tbl[i]) begin
         fetch_req = tbl[i].req; fetch_pc = tbl[i].pc; flush = tbl[i].fl;
         mem_req_ready = tbl[i].rdy; mem_rsp_valid = tbl[i].rv; mem_rsp_data = tbl[i].dat;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_done,
                 tbl[i].e_busy, tbl[i].e_mis, L, tbl[i].e_instr);
      end
      idle_inputs();

      // reset asserted in the middle of WAIT
      fetch_req = H; fetch_pc = 32'h7000; step(); fetch_req = L;
      mem_req_ready = H; step(); mem_req_ready = L;
      chk_all("rw wait", L, 32'h7000, L, H, L, L, 32'h00A0_0113);
      #2 rst_n = L;
      #1 reset_outputs_zero("rw async");
      @(posedge clk); #1;
      reset_outputs_zero("rw held");
      rst_n = H;
      mem_rsp_valid = H; mem_rsp_data = 32'h1234_5678; step(); mem_rsp_valid = L;
      chk_all("rw late rsp", L, 32'h0, L, L, L, L, 32'h0);

      // ready withheld five cycles, then no response until timeout
      fetch_req = H; fetch_pc = 32'h5000; step(); fetch_req = L;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("to stall%0d", i), H, 32'h5000, L, H, L, L, 32'h0);
      end
      mem_req_ready = H; step(); mem_req_ready = L;
      chk_all("to wait", L, 32'h5000, L, H, L, L, 32'h0);
      for (int k = 1; k <= TO; k++) begin
         step();
         chk_all($sformatf("to k%0d", k), L, 32'h5000, L, k < TO, L, k == TO, 32'h0);
      end
      step();
      chk_all("to after", L, 32'h5000, L, L, L, L, 32'h0);

      exp_instr = '0;
      exp_addr  = 32'h5000;
      for (int n = 0; n < 60; n++) begin
         rand_txn(n);
         repeat ($urandom_range(0, 2)) begin
            mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom;
            step();
            mem_rsp_valid = L;
            chk_all("gap", L, exp_addr, L, L, L, L, exp_instr);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
